// File: rtl/shift_rr_scheduler_pkg.sv
// Shared definitions for shift_rr_scheduler.
//   sw_of / idw_of : derived widths of the shift-amount and requester-id fields
//   clamp_shift    : limits a requested shift distance to the legal maximum
// The request record {data, shift, id} depends on the per-instance widths, so
// it is declared as req_t inside the top using the widths from these helpers.
package shift_rr_scheduler_pkg;

   // Width of a shift-amount field able to hold 0..max_shift.
   function automatic int sw_of(input int max_shift);
      return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
   endfunction

   // Width of a requester index, never below one bit.
   function automatic int idw_of(input int n_req);
      return (n_req <= 2) ? 1 : $clog2(n_req);
   endfunction

   // Shift fields can encode more than max_shift when max_shift+1 is not a
   // power of two; such requests saturate at max_shift.
   function automatic int unsigned clamp_shift(input int unsigned sh,
                                               input int unsigned max_shift);
      return (sh > max_shift) ? max_shift : sh;
   endfunction

endpackage

// File: rtl/shift_rr_scheduler_barrel.sv
// barrel_shift: log-depth arithmetic right shifter (sign fill).
//   din   : two's complement operand
//   shift : shift distance, already within 0..MAX_SHIFT
//   dout  : din >>> shift
module barrel_shift
   import shift_rr_scheduler_pkg::*;
#(
   parameter  int WIDTH     = 48,
   parameter  int MAX_SHIFT = 15,
   localparam int SW        = sw_of(MAX_SHIFT)
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SW-1:0]    shift,
   output logic [WIDTH-1:0] dout
);

   // lvl[j] holds the operand after the low j shift bits have been applied.
   logic [SW:0][WIDTH-1:0] lvl;

   assign lvl[0] = din;

   for (genvar j = 0; j < SW; j++) begin : g_lvl
      assign lvl[j+1] = shift[j] ? WIDTH'($signed(lvl[j]) >>> (1 << j)) : lvl[j];
   end

   assign dout = lvl[SW];

endmodule

// File: rtl/shift_rr_scheduler_rr_grant.sv
// rr_grant: combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester
//   any   : at least one request granted
module rr_grant
   import shift_rr_scheduler_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = idw_of(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   idx,
   output logic             any
);

   int k;

   // Walk the requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      k     = 0;
      for (int off = 0; off < N_REQ; off++) begin
         k = (int'(ptr) + off) % N_REQ;
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/shift_rr_scheduler.sv
// shift_rr_scheduler: N_REQ requesters share one arithmetic-right-shift
// datapath through a round-robin arbiter and a 2-stage pipeline
// (operand register s1, result register s2 = rsp_*).
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_data, req_shift : per-requester operand and shift distance
//   rsp_valid/rsp_ready : result handshake
//   rsp_data, rsp_id    : shifted result and originating requester
//   busy                : either pipeline stage occupied
module shift_rr_scheduler
   import shift_rr_scheduler_pkg::*;
#(
   parameter  int WIDTH     = 48,
   parameter  int MAX_SHIFT = 15,
   parameter  int N_REQ     = 4,
   localparam int SW        = sw_of(MAX_SHIFT),
   localparam int IDW       = idw_of(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   input  logic [N_REQ*SW-1:0]    req_shift,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [IDW-1:0]         rsp_id,
   output logic                   busy
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SW-1:0]    shift;
      logic [IDW-1:0]   id;
   } req_t;

   logic [IDW-1:0]   ptr;
   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   gidx;
   logic             gany;
   logic             s1_valid;
   req_t             s1;
   req_t             sel;
   logic             s1_free, s2_free, accept;
   logic [SW-1:0]    sh_eff;
   logic [WIDTH-1:0] shifted;

   // Grant looks only at req_valid and ptr; readiness gates it afterwards.
   rr_grant #(.N_REQ(N_REQ)) u_grant (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // rsp_ready reaches req_ready combinationally so a full pipe keeps streaming.
   assign s2_free   = !rsp_valid || rsp_ready;
   assign s1_free   = !s1_valid || s2_free;
   assign req_ready = grant & {N_REQ{s1_free}};
   assign accept    = gany && s1_free;

   assign sel.data  = req_data[int'(gidx)*WIDTH +: WIDTH];
   assign sel.shift = req_shift[int'(gidx)*SW +: SW];
   assign sel.id    = gidx;

   assign sh_eff = SW'(clamp_shift(32'(s1.shift), MAX_SHIFT));

   barrel_shift #(.WIDTH(WIDTH), .MAX_SHIFT(MAX_SHIFT)) u_shift (
      .din   (s1.data),
      .shift (sh_eff),
      .dout  (shifted)
   );

   // Priority moves just past the winner; holds when nothing is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + 1'b1;
      end
   end

   // Stage 1: refills (or empties) whenever its contents can move on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (s1_free) begin
         s1_valid <= accept;
         if (accept) s1 <= sel;
      end
   end

   // Stage 2: frozen under backpressure, otherwise takes the shifted s1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else if (s2_free) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_data <= shifted;
            rsp_id   <= s1.id;
         end
      end
   end

   assign busy = s1_valid || rsp_valid;

endmodule

// File: tb/tb_shift_rr_scheduler.sv
// Scoreboard bench for shift_rr_scheduler: the stimulus side pushes the
// hand-computed response of every accepted operand; monitors pop and compare
// whenever a response handshake completes.
module tb_shift_rr_scheduler;

   localparam int W = 48;
   localparam int N = 4;
   localparam int S = 4;

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_valid_b;
   logic [N-1:0]   req_ready, req_ready_b;
   logic [N*W-1:0] req_data, req_data_b;
   logic [N*S-1:0] req_shift, req_shift_b;
   logic           rsp_valid, rsp_valid_b, rsp_ready, rsp_ready_b;
   logic [W-1:0]   rsp_data, rsp_data_b;
   logic [1:0]     rsp_id, rsp_id_b;
   logic           busy, busy_b;

   exp_t q[$];
   exp_t qb[$];
   exp_t em, emb;
   int   n_cmp = 0;
   int   n_err = 0;
   int   eptr;

   // Per-requester traffic operands and their hand-computed results.
   logic [W-1:0] dtab [N] = '{48'hFFFF_FFFF_FF00, 48'h0000_0000_1000,
                              48'h8000_0000_0001, 48'h7FFF_0000_0000};
   logic [S-1:0] stab [N] = '{4'd4, 4'd12, 4'd0, 4'd8};
   logic [W-1:0] etab [N] = '{48'hFFFF_FFFF_FFF0, 48'h0000_0000_0001,
                              48'h8000_0000_0001, 48'h007F_FF00_0000};

   shift_rr_scheduler #(.WIDTH(W), .MAX_SHIFT(15), .N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_shift(req_shift), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
   );

   shift_rr_scheduler #(.WIDTH(W), .MAX_SHIFT(12), .N_REQ(N)) dut12 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_data(req_data_b), .req_shift(req_shift_b), .rsp_valid(rsp_valid_b),
      .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_id(rsp_id_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, expv);
      end
   endtask

   // Monitors: one pop per completed response handshake.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp: got id %0d data %h, required none", rsp_id, rsp_data);
         end else begin
            em = q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(em.id));
            check("rsp_data", 64'(rsp_data), 64'(em.data));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rsp_valid_b && rsp_ready_b) begin
         if (qb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp_b: got id %0d data %h, required none", rsp_id_b, rsp_data_b);
         end else begin
            emb = qb.pop_front();
            check("rsp_id_b", 64'(rsp_id_b), 64'(emb.id));
            check("rsp_data_b", 64'(rsp_data_b), 64'(emb.data));
         end
      end
   end

   // Single request on one port; waits (bounded) for its accept.
   task automatic drive_one(input int id, input logic [W-1:0] d, input logic [S-1:0] sh,
                            input logic [W-1:0] expv);
      bit ok = 0;
      @(posedge clk); #1;
      req_data[id*W +: W]  = d;
      req_shift[id*S +: S] = sh;
      req_valid            = N'(1 << id);
      rsp_ready            = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            ok = 1;
            check("grant_one", 64'(req_ready), 64'(1 << id));
            q.push_back('{id: 2'(id), data: expv});
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: got no accept on port %0d, required one", id);
      end
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   // Requesters in vmask stay valid for ncyc cycles; rsp_ready drops for
   // stall_len cycles starting at cycle stall_from. ep is the expected pointer.
   task automatic traffic(input logic [N-1:0] vmask, input int ncyc, input int stall_from,
                          input int stall_len, inout int ep);
      logic [N-1:0] acc;
      logic [W-1:0] hd;
      logic [1:0]   hi;
      int           eid;
      bit           st;
      hd = '0; hi = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i*W +: W]  = dtab[i];
         req_shift[i*S +: S] = stab[i];
      end
      for (int c = 0; c < ncyc; c++) begin
         st = (c >= stall_from) && (c < stall_from + stall_len);
         @(posedge clk); #1;
         req_valid = vmask;
         rsp_ready = !st;
         @(negedge clk);
         acc = req_valid & req_ready;
         if (st) begin
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_valid", 64'(rsp_valid), 64'(1));
            if (c == stall_from) begin
               hd = rsp_data; hi = rsp_id;
            end else begin
               check("stall_data", 64'(rsp_data), 64'(hd));
               check("stall_id", 64'(rsp_id), 64'(hi));
            end
         end else begin
            eid = -1;
            for (int o = 0; o < N; o++)
               if (eid < 0 && vmask[(ep + o) % N]) eid = (ep + o) % N;
            check("rr_grant", 64'(acc), 64'(1 << eid));
            q.push_back('{id: 2'(eid), data: etab[eid]});
            ep = (eid + 1) % N;
         end
      end
   endtask

   task automatic drain();
      @(posedge clk); #1;
      req_valid   = '0;
      req_valid_b = '0;
      rsp_ready   = 1'b1;
      rsp_ready_b = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (q.size() == 0 && qb.size() == 0 && !busy && !busy_b) break;
      end
      check("drain_q", 64'(q.size()), 64'(0));
      check("drain_qb", 64'(qb.size()), 64'(0));
      check("drain_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish within budget");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_data = '0; req_shift = '0; rsp_ready = 1'b1;
      req_valid_b = '0; req_data_b = '0; req_shift_b = '0; rsp_ready_b = 1'b1;
      #12;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_data", 64'(rsp_data), 64'(0));
      check("rst_rsp_id", 64'(rsp_id), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single accept, latency and busy window.
      check("t1_idle_busy", 64'(busy), 64'(0));
      drive_one(0, 48'hFFFF_FFFF_FF00, 4'd4, 48'hFFFF_FFFF_FFF0);
      @(negedge clk);
      check("t1_s1_only", 64'(rsp_valid), 64'(0));
      check("t1_busy_s1", 64'(busy), 64'(1));
      @(negedge clk);
      check("t1_rsp_valid", 64'(rsp_valid), 64'(1));
      check("t1_busy_s2", 64'(busy), 64'(1));
      @(negedge clk);
      check("t1_rsp_drop", 64'(rsp_valid), 64'(0));
      check("t1_busy_end", 64'(busy), 64'(0));

      // 2: right shift by 12, shift 0 passthrough, all-ones stays -1.
      drive_one(2, 48'h0000_0000_1000, 4'd12, 48'h0000_0000_0001);
      drive_one(2, 48'h8000_0000_0001, 4'd0, 48'h8000_0000_0001);
      drive_one(1, 48'hFFFF_FFFF_FFFF, 4'd15, 48'hFFFF_FFFF_FFFF);
      drain();

      // 3: all four continuously valid; pointer sits at 2 after the above.
      eptr = 2;
      traffic(4'hF, 12, -1, 0, eptr);
      // 4: same traffic with a 3-cycle response stall.
      traffic(4'hF, 14, 4, 3, eptr);
      drain();

      // 5: MAX_SHIFT=12 instance clamps shift 15 down to 12.
      @(posedge clk); #1;
      req_data_b[W-1:0]  = 48'h8000_0000_0000;
      req_shift_b[S-1:0] = 4'd15;
      req_valid_b        = 4'b0001;
      @(negedge clk);
      check("t5_grant", 64'(req_ready_b), 64'(1));
      qb.push_back('{id: 2'd0, data: 48'hFFF8_0000_0000});
      drain();

      // 6: reset with both stages full discards them; pointer restarts at 0.
      traffic(4'hF, 4, -1, 0, eptr);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = '0;
      @(negedge clk);
      check("t6_full_busy", 64'(busy), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(rsp_valid), 64'(0));
      check("t6_rst_data", 64'(rsp_data), 64'(0));
      check("t6_rst_id", 64'(rsp_id), 64'(0));
      check("t6_rst_busy", 64'(busy), 64'(0));
      check("t6_rst_ready", 64'(req_ready), 64'(0));
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      eptr = 0;
      traffic(4'b1001, 2, -1, 0, eptr);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_rr_scheduler.md
Name: shift_rr_scheduler

Overview:
Shares one arithmetic-right-shift datapath (log-depth barrel tree, sign-extending) between N_REQ AdaIN requesters, such as per-channel normalisation lanes.
Arbitration is round-robin with a valid/ready handshake on each requester port. Accepted operands pass through a 2-stage pipeline: operand register, then shift result register.
The single result port returns the shifted value tagged with the requester index.

Parameters:
WIDTH, 48, operand/result width (two's complement)
MAX_SHIFT, 15, largest legal shift distance
N_REQ, 4, number of requesters (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester operand valid
req_ready  output  N_REQ  per-requester accept (one-hot or zero)
req_data  input  N_REQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
req_shift  input  N_REQ*SW  shift amounts, SW=$clog2(MAX_SHIFT+1), requester i at [i*SW +: SW]
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accept
rsp_data  output  WIDTH  arithmetic-right-shifted result
rsp_id  output  IDW  requester index, IDW=max(1,$clog2(N_REQ))
busy  output  1  any pipeline stage occupied

Behaviour:
- Reset (async assert, sync release): s1_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr pointer=0, busy=0. Reset mid-operation discards in-flight operands; no response is emitted for them.
- Grant: combinational round-robin among asserted req_valid. Search starts at the pointer and wraps modulo N_REQ. grant is one-hot or zero. It depends only on req_valid and the pointer, never on ready.
- Stall logic:
  - s2_free = !rsp_valid | rsp_ready
  - s1_free = !s1_valid | s2_free
  - req_ready[i] = grant[i] & s1_free
  - The combinational path rsp_ready->req_ready is intentional.
- Handshake: requester i is accepted when req_valid[i] & req_ready[i]. On accept, s1 captures data, shift and id, and the pointer becomes (i+1) mod N_REQ. With no accept, the pointer holds.
- Shift clamp: if MAX_SHIFT is not 2^SW-1, a shift >MAX_SHIFT is clamped to MAX_SHIFT before the shift. Shift 0 passes data unchanged.
- Arithmetic: result = operand >>> shift with sign fill. A negative operand never becomes positive (-1 >>> k = -1).
- Stage 2:
  - When s2_free and s1_valid, rsp_data/rsp_id load the shifted s1 contents and rsp_valid=1.
  - When s2_free and !s1_valid, rsp_valid drops to 0.
  - s1 clears when it advances and nothing new is accepted.
- Latency: an operand accepted at edge k appears with rsp_valid=1 after edge k+1. Throughput is 1 result/cycle with no bubbles under continuous traffic.
- Backpressure: while rsp_valid & !rsp_ready, rsp_data/rsp_id/rsp_valid hold stable. s1 holds if occupied, and all req_ready are 0 once s1 is full. No drops and no duplicates.
- Simultaneous events: acceptance into s1 and advance of s1 into s2 in the same cycle are legal (pipeline flow).
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- busy = s1_valid | rsp_valid.

Decomposition:
- Shared package holds:
  - function/localparams SW and IDW
  - shift-clamp helper function
  - request record typedef {data, shift, id}
- Natural sub-module: rr_grant (combinational one-hot round-robin from request vector + pointer; outputs grant and granted index).
- The shift datapath is one instance of the existing barrel-shift tree with WIDTH/MAX_SHIFT passed through.

Test Plan:
1. Req0 only, data 0xFFFF_FFFF_FF00, shift 4, rsp_ready=1 -> rsp_data 0xFFFF_FFFF_FFF0, rsp_id 0, rsp_valid one cycle after the accept edge; busy high for those cycles only.
2. Req2 only, data 0x0000_0000_1000, shift 12 -> 0x0000_0000_0001, id 2; then shift 0 on 0x8000_0000_0001 -> unchanged.
3. All 4 requesters continuously valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1... at one per cycle after 2-cycle fill; each req_ready one-hot.
4. Continuous traffic, rsp_ready low 3 cycles -> rsp_data/rsp_id frozen, req_ready all 0 after s1 fills. After release, the sequence resumes with no loss or duplication (scoreboard by id/data).
5. Build MAX_SHIFT=12 (SW=4): data 0x8000_0000_0000, shift 15 -> clamped, rsp_data 0xFFF8_0000_0000.
6. rst_n asserted while s1 and s2 are full -> all outputs 0 immediately. After release, a new request to req3 returns only its own result; the pointer restarts at 0 (req0 wins a tie).
